// File: rtl/throw_ypos_gen.sv
// throw_ypos_gen: vertical position generator for a thrown projectile (rise, apex, fall, land)
// Ports:
//   clk60MHz  in            clock, rising edge
//   rst       in            synchronous active-high reset
//   start     in            launch request, accepted only in IDLE for PLAYER_1/PLAYER_2
//   player    in  [1:0]     current player
//   v0        in  [SW-1:0]  initial upward speed, sampled on launch (0 treated as 1)
//   abort     in            cancel a throw in progress
//   ypos      out [YW-1:0]  registered vertical position
//   busy      out           high whenever not IDLE
//   apex      out           one-cycle pulse at the top of the arc
//   landed    out           one-cycle pulse on final ground contact
// Optional macro THROW_BOUNCE_EN: one bounce at half speed on a hard first landing.
package variable_pkg;
    localparam logic [1:0] PLAYER_1 = 2'b01;
    localparam logic [1:0] PLAYER_2 = 2'b10;
endpackage

module throw_ypos_gen #(
    parameter int YW = 12,
    parameter int SW = 6,
    parameter int UP_TICK = 250000,
    parameter int DOWN_TICK = 100000,
    parameter int Y_REST = 768,
    parameter int Y_START = 454,
    parameter int Y_GROUND = 768
) (
    input  logic          clk60MHz,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    player,
    input  logic [SW-1:0] v0,
    input  logic          abort,
    output logic [YW-1:0] ypos,
    output logic          busy,
    output logic          apex,
    output logic          landed
);
    import variable_pkg::*;
    localparam int TMAX = UP_TICK > DOWN_TICK ? UP_TICK : DOWN_TICK;
    localparam int CW = TMAX > 1 ? $clog2(TMAX) : 1;
    localparam int YW1 = YW + 1;
    localparam logic [CW-1:0] UP_LAST = CW'(UP_TICK - 1);
    localparam logic [CW-1:0] DOWN_LAST = CW'(DOWN_TICK - 1);
`ifdef THROW_BOUNCE_EN
    typedef enum logic [1:0] {IDLE, RISE, FALL, BOUNCE_RISE} state_t;
    logic bounced, bounced_n;
`else
    typedef enum logic [1:0] {IDLE, RISE, FALL} state_t;
`endif
    state_t state, state_n;
    logic [YW-1:0] ypos_n;
    logic [SW-1:0] speed, speed_n, speed_dec, speed_inc;
    logic [CW-1:0] cnt, cnt_n;
    logic [YW:0] sum;
    logic apex_n, landed_n, last, clamp, ground;

    assign busy = state != IDLE;

    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state <= IDLE;
            ypos <= YW'(Y_REST);
            speed <= '0;
            cnt <= '0;
            apex <= 1'b0;
            landed <= 1'b0;
`ifdef THROW_BOUNCE_EN
            bounced <= 1'b0;
`endif
        end else begin
            state <= state_n;
            ypos <= ypos_n;
            speed <= speed_n;
            cnt <= cnt_n;
            apex <= apex_n;
            landed <= landed_n;
`ifdef THROW_BOUNCE_EN
            bounced <= bounced_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        ypos_n = ypos;
        speed_n = speed;
        cnt_n = cnt;
        apex_n = 1'b0;
        landed_n = 1'b0;
`ifdef THROW_BOUNCE_EN
        bounced_n = bounced;
`endif
        last = (state == FALL) ? (cnt == DOWN_LAST) : (cnt == UP_LAST);
        clamp = ypos < YW'(speed);
        // one extra bit so the landing test cannot wrap near the top of the range
        sum = {1'b0, ypos} + YW1'(speed);
        ground = sum >= YW1'(Y_GROUND);
        speed_dec = speed - 1'b1;
        speed_inc = &speed ? speed : speed + 1'b1;
        if (state == IDLE) begin
            ypos_n = YW'(Y_REST);
            speed_n = v0;
            cnt_n = '0;
`ifdef THROW_BOUNCE_EN
            bounced_n = 1'b0;
`endif
            if (start && !abort && (player == PLAYER_1 || player == PLAYER_2)) begin
                state_n = RISE;
                ypos_n = YW'(Y_START);
                speed_n = (v0 == '0) ? SW'(1) : v0;
            end
        end else if (abort) begin
            state_n = IDLE;
            ypos_n = YW'(Y_REST);
            cnt_n = '0;
        end else if (!last) begin
            cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
            if (state == FALL) begin
                ypos_n = ground ? YW'(Y_GROUND) : sum[YW-1:0];
                speed_n = speed_inc;
                if (ground) begin
`ifdef THROW_BOUNCE_EN
                    if (!bounced && speed >= SW'(4)) begin
                        state_n = BOUNCE_RISE;
                        speed_n = speed >> 1;
                        bounced_n = 1'b1;
                    end else
`endif
                    begin
                        state_n = IDLE;
                        landed_n = 1'b1;
                    end
                end
            end else begin
                ypos_n = clamp ? '0 : ypos - YW'(speed);
                speed_n = speed_dec;
                if (clamp || speed_dec <= SW'(1)) begin
                    state_n = FALL;
                    apex_n = state == RISE;
                end
            end
        end
    end
endmodule

// File: tb/tb_throw_ypos_gen.sv
// tb_throw_ypos_gen: randomized throws checked against a per-tick trajectory model
module tb_throw_ypos_gen;
    import variable_pkg::*;
    localparam int UP = 4;
    localparam int DN = 2;
    localparam int Y_REST = 768;
    localparam int Y_START = 454;
    localparam int Y_GROUND = 768;
`ifdef THROW_BOUNCE_EN
    localparam bit BOUNCE = 1'b1;
`else
    localparam bit BOUNCE = 1'b0;
`endif

    typedef struct {
        int y;
        bit b;
        bit a;
        bit l;
        bit ft;
    } smp_t;

    logic clk60MHz = 0, rst = 1, start = 0, abort = 0;
    logic [1:0] player = 0;
    logic [5:0] v0 = 0;
    logic [11:0] ypos;
    logic busy, apex, landed;
    int checks = 0, failures = 0;
    smp_t exp_q[$];

    throw_ypos_gen #(.UP_TICK(UP), .DOWN_TICK(DN)) dut (
        .clk60MHz(clk60MHz), .rst(rst), .start(start), .player(player), .v0(v0),
        .abort(abort), .ypos(ypos), .busy(busy), .apex(apex), .landed(landed)
    );

    always #8 clk60MHz = ~clk60MHz;

    task automatic step();
        @(posedge clk60MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ypos"}, 32'(ypos), Y_REST);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_apex"}, 32'(apex), 0);
        chk({tag, "_landed"}, 32'(landed), 0);
    endtask

    task automatic push(input int y, input bit b, input bit a, input bit l);
        smp_t s;
        s.y = y;
        s.b = b;
        s.a = a;
        s.l = l;
        s.ft = 0;
        exp_q.push_back(s);
    endtask

    // One entry per clock after the launch edge: position holds for a full
    // period, then moves by the current speed on the update tick.
    task automatic build_model(input int v);
        int y, s;
        bit rising, apex_ok, bounced, top;
        exp_q.delete();
        y = Y_START;
        s = (v == 0) ? 1 : v;
        rising = 1;
        apex_ok = 1;
        bounced = 0;
        push(y, 1, 0, 0);
        for (int k = 0; k < 1000; k++) begin
            for (int i = 1; i < (rising ? UP : DN); i++) push(y, 1, 0, 0);
            if (!rising) exp_q[$].ft = 1;
            if (rising) begin
                top = y < s;
                y = top ? 0 : y - s;
                s = s - 1;
                top = top || s <= 1;
                push(y, 1, top && apex_ok, 0);
                if (top) rising = 0;
            end else if (y + s >= Y_GROUND) begin
                y = Y_GROUND;
                if (BOUNCE && !bounced && s >= 4) begin
                    s = s / 2;
                    bounced = 1;
                    rising = 1;
                    apex_ok = 0;
                    push(y, 1, 0, 0);
                end else begin
                    push(y, 0, 0, 1);
                    break;
                end
            end else begin
                y = y + s;
                s = (s < 63) ? s + 1 : 63;
                push(y, 1, 0, 0);
            end
        end
    endtask

    // abort_mode: 0 none, 1 random cycle, 2 first falling update tick, 3 reset at random cycle
    task automatic run_throw(input int v, input logic [1:0] pl, input int abort_mode, input string tag);
        int n, cut, intr;
        build_model(v);
        n = exp_q.size();
        cut = -1;
        if (abort_mode == 1 || abort_mode == 3) cut = $urandom_range(0, n - 2);
        if (abort_mode == 2) begin
            for (int i = 0; i < n; i++) if (exp_q[i].ft && cut < 0) cut = i;
        end
        intr = $urandom_range(0, n - 2);
        start = 1;
        player = pl;
        v0 = 6'(v);
        step();
        start = 0;
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_ypos[%0d]", tag, i), 32'(ypos), exp_q[i].y);
            chk($sformatf("%s_busy[%0d]", tag, i), 32'(busy), 32'(exp_q[i].b));
            chk($sformatf("%s_apex[%0d]", tag, i), 32'(apex), 32'(exp_q[i].a));
            chk($sformatf("%s_landed[%0d]", tag, i), 32'(landed), 32'(exp_q[i].l));
            if (i == cut) begin
                if (abort_mode == 3) rst = 1;
                else abort = 1;
                step();
                rst = 0;
                abort = 0;
                chk_idle({tag, "_cut"});
                step();
                chk_idle({tag, "_cut2"});
                return;
            end
            if (i < n - 1) begin
                start = (i == intr) || ($urandom_range(0, 7) == 0);
                player = (i == intr) ? PLAYER_1 : 2'($urandom);
                v0 = (i == intr) ? 6'd20 : 6'($urandom);
                step();
                start = 0;
            end
        end
        step();
        chk_idle({tag, "_after"});
    endtask

    initial begin
        rst = 1;
        repeat (3) step();
        rst = 0;
        chk_idle("reset");
        run_throw(3, PLAYER_1, 0, "v3");
        run_throw(0, PLAYER_2, 0, "v0zero");
        start = 1;
        player = 2'b00;
        v0 = 6'd10;
        step();
        start = 0;
        chk_idle("bad_player0");
        step();
        chk_idle("bad_player0b");
        start = 1;
        player = 2'b11;
        step();
        start = 0;
        chk_idle("bad_player3");
        start = 1;
        abort = 1;
        player = PLAYER_1;
        step();
        start = 0;
        abort = 0;
        chk_idle("start_abort");
        abort = 1;
        step();
        abort = 0;
        chk_idle("idle_abort");
        run_throw(20, PLAYER_1, 0, "v20");
        run_throw(3, PLAYER_1, 2, "fall_abort");
        run_throw(63, PLAYER_2, 0, "v63");
        run_throw(12, PLAYER_1, 3, "mid_reset");
        for (int t = 0; t < 20; t++) begin
            int m;
            m = $urandom_range(0, 4);
            run_throw($urandom_range(0, 63), $urandom_range(0, 1) ? PLAYER_1 : PLAYER_2,
                      m > 3 ? 0 : m, $sformatf("rnd%0d", t));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/throw_ypos_gen.md
THROW_YPOS_GEN -- requirements
Module: throw_ypos_gen

Interface
REQ-001 Parameter YW, default 12: width of the vertical position in pixels.
REQ-002 Parameter SW, default 6: width of the speed register.
REQ-003 Parameter UP_TICK, default 250000: clock cycles per position update while rising.
REQ-004 Parameter DOWN_TICK, default 100000: clock cycles per position update while falling.
REQ-005 Parameter Y_REST, default 768: position held while idle.
REQ-006 Parameter Y_START, default 454: launch position.
REQ-007 Parameter Y_GROUND, default 768: landing position.
REQ-008 Port clk60MHz, in, 1: clock; all logic is on its rising edge.
REQ-009 Port rst, in, 1: reset, synchronous, active-high.
REQ-010 Port start, in, 1: launch request pulse.
REQ-011 Port player, in, 2: current player, compared against PLAYER_1 and PLAYER_2 from variable_pkg.
REQ-012 Port v0, in, SW: initial upward speed, sampled only when a launch is accepted.
REQ-013 Port abort, in, 1: cancels a throw in progress.
REQ-014 Port ypos, out, YW: registered vertical position.
REQ-015 Port busy, out, 1: high in every state except IDLE.
REQ-016 Port apex, out, 1: one-cycle pulse when the projectile reaches the top of its arc.
REQ-017 Port landed, out, 1: one-cycle pulse on the final ground contact.

Function
REQ-018 State machine: IDLE, RISE, FALL; BOUNCE_RISE is added only when the Configuration macro is defined.
REQ-019 Launch accept: in IDLE, start=1 and player equal to PLAYER_1 or PLAYER_2.
- Next cycle: ypos=Y_START, speed=v0, tick counter=0, state=RISE.
- v0=0 is loaded as 1.
REQ-020 IDLE otherwise: ypos=Y_REST, speed=v0, tick counter=0. start with any other player value is ignored.
REQ-021 In IDLE the tick counter is held at 0.
- RISE and FALL: the counter increments each cycle.
- On reaching the period minus 1 (UP_TICK-1 in RISE, DOWN_TICK-1 in FALL), the cycle is an update tick and the counter returns to 0.
REQ-022 RISE update tick: ypos -= speed and speed -= 1.
- If ypos < speed, ypos clamps to 0.
- If the new speed is 1 or less, or ypos clamped: state=FALL and apex=1 in that same cycle.
REQ-023 FALL update tick: ypos += speed and speed += 1.
- speed saturates at 2^SW-1.
REQ-024 FALL update tick where ypos+speed >= Y_GROUND (evaluated without overflow): ypos=Y_GROUND exactly.
- This counts as a ground contact.
- On the final contact: landed=1, state=IDLE.
REQ-025 Ypos changes only on update ticks and on the entry/exit transitions above.
REQ-026 start while busy=1 is ignored; v0 is not re-sampled.
REQ-027 abort=1 in any non-IDLE state: next cycle state=IDLE, ypos=Y_REST.
- No apex or landed pulse is produced.
- abort takes priority over a simultaneous tick or landing.
REQ-028 abort in IDLE has no effect; start and abort asserted together in IDLE produce no launch.

Reset
REQ-029 rst has priority over all other inputs, including mid-throw.
REQ-030 Reset values: state=IDLE, ypos=Y_REST, speed=0, tick counter=0, apex=0, landed=0, busy=0.

Configuration
REQ-031 Macro THROW_BOUNCE_EN.
- Defined: on the first ground contact with speed >= 4, speed=speed>>1 and state=BOUNCE_RISE, with no landed pulse.
- BOUNCE_RISE behaves as RISE except that no apex pulse is generated.
- The second ground contact, or a first contact with speed < 4, is final.
- The bounce count clears in IDLE.
REQ-032 Undefined: every ground contact is final, BOUNCE_RISE and the bounce logic are absent, and the ports are identical.

Verification (UP_TICK=4, DOWN_TICK=2, other parameters at default)
REQ-033 rst held high for 3 cycles -> ypos=768, busy=0, apex=0, landed=0.
REQ-034 start with player=PLAYER_1 and v0=3.
- Expected next cycle: ypos=454, busy=1.
- Expected on the 1st update tick: ypos=451.
- Expected on the 2nd update tick: ypos=449, apex=1, state=FALL.
REQ-035 Continue REQ-034 -> ypos rises by 1, 2, 3, ... per tick until landed=1 with ypos=768 exactly; the next cycle has busy=0.
REQ-036 start with player=2'b00 -> no launch; start pulsed during RISE with v0=20 -> the trajectory is unchanged.
REQ-037 abort asserted during FALL on an update tick -> next cycle ypos=768, busy=0, landed never pulses.
REQ-038 THROW_BOUNCE_EN defined, v0=20.
- Expected at the first contact: speed is halved, state=BOUNCE_RISE, landed=0.
- Expected at the second contact: landed=1.
- The same test with the macro undefined: landed=1 at the first contact.
